// File: rtl/spi_sensor_packet_rx.sv
// spi_sensor_packet_rx
// Read-only SPI Mode 0 slave that receives sensor packets from the Arduino
// master. SCK, CS and MOSI are oversampled in the clk domain. Each packet is
// header, sensor id, NUM_FIELDS signed 16-bit fields (MSB byte first), a flags
// byte and an XOR checksum. Good packets update a per-sensor register bank.
//
// Ports:
//   clk, rst_n      system clock (>= 4x SCK) and async active-low reset
//   cs_n, sck, sdi  raw asynchronous SPI inputs
//   field_data      per-sensor field bank, sensor s field f at [(s*NUM_FIELDS+f)*16 +: 16]
//   field_flags     last committed flags byte per sensor
//   sensor_seen     bit s set once sensor s has committed a packet
//   pkt_valid       one-cycle strobe per committed packet
//   pkt_sensor      sensor id of the last commit
//   frame_err_cnt   saturating count of short/long/bad-header frames
//   csum_err_cnt    saturating count of checksum failures
//   id_err_cnt      saturating count of out-of-range sensor ids
//   busy            high while a frame is being received
module spi_sensor_packet_rx #(
    parameter int          NUM_SENSORS = 2,
    parameter int          NUM_FIELDS  = 6,
    parameter logic [7:0]  HEADER_BYTE = 8'hAA,
    localparam int         PKT_BYTES   = 2*NUM_FIELDS+4,
    localparam int         ID_W        = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cs_n,
    input  logic                             sck,
    input  logic                             sdi,
    output logic [NUM_SENSORS*NUM_FIELDS*16-1:0] field_data,
    output logic [NUM_SENSORS*8-1:0]         field_flags,
    output logic [NUM_SENSORS-1:0]           sensor_seen,
    output logic                             pkt_valid,
    output logic [ID_W-1:0]                  pkt_sensor,
    output logic [7:0]                       frame_err_cnt,
    output logic [7:0]                       csum_err_cnt,
    output logic [7:0]                       id_err_cnt,
    output logic                             busy
);

    localparam int BC_W = $clog2(PKT_BYTES+1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECV   = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]      state;
    logic [2:0]      cs_sync;
    logic [2:0]      sck_sync;
    logic [1:0]      sdi_sync;
    logic [2:0]      sync_prime;
    logic            cs_pending;
    logic [2:0]      bit_cnt;
    logic [BC_W-1:0] byte_cnt;
    logic [7:0]      shift_reg;
    logic [7:0]      csum;
    logic            overrun;
    logic [7:0]      stage [PKT_BYTES];

    logic            cs_fall;
    logic            cs_rise;
    logic            sck_rise;
    logic [7:0]      shift_next;
    logic            len_bad;
    logic            hdr_bad;
    logic            csum_bad;
    logic            id_bad;
    logic            frame_good;
    logic [ID_W-1:0] commit_id;

    // Synchronisers. sync_prime marks when every cs stage holds a real sample,
    // so the reset preset of cs=1 can never fake a falling edge while the
    // master is still mid-frame at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync    <= 3'b111;
            sck_sync   <= 3'b000;
            sdi_sync   <= 2'b00;
            sync_prime <= 3'b000;
        end else begin
            cs_sync    <= {cs_sync[1:0], cs_n};
            sck_sync   <= {sck_sync[1:0], sck};
            sdi_sync   <= {sdi_sync[0], sdi};
            sync_prime <= {sync_prime[1:0], 1'b1};
        end
    end

    assign cs_fall    = sync_prime[2] & cs_sync[2] & ~cs_sync[1];
    assign cs_rise    = ~cs_sync[2] & cs_sync[1];
    assign sck_rise   = sck_sync[1] & ~sck_sync[2] & ~cs_sync[1];
    assign shift_next = {shift_reg[6:0], sdi_sync[1]};

    assign len_bad    = (byte_cnt != BC_W'(PKT_BYTES)) || (bit_cnt != 3'd0) || overrun;
    assign hdr_bad    = (stage[0] != HEADER_BYTE);
    assign csum_bad   = (csum != stage[PKT_BYTES-1]);
    assign id_bad     = (32'(stage[1]) >= 32'(NUM_SENSORS));
    assign frame_good = !len_bad && !hdr_bad && !csum_bad && !id_bad;
    assign commit_id  = stage[1][ID_W-1:0];
    assign busy       = (state == ST_RECV);

    // Receive FSM: frame capture into the staging buffer and frame evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cs_pending <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            shift_reg  <= 8'd0;
            csum       <= 8'd0;
            overrun    <= 1'b0;
            for (int i = 0; i < PKT_BYTES; i++) stage[i] <= 8'd0;
        end else begin
            if (cs_fall && (state == ST_CHECK || state == ST_COMMIT))
                cs_pending <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cs_fall || cs_pending) begin
                        cs_pending <= 1'b0;
                        bit_cnt    <= 3'd0;
                        byte_cnt   <= '0;
                        csum       <= 8'd0;
                        overrun    <= 1'b0;
                        state      <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (cs_rise) begin
                        state <= ST_CHECK;
                    end else if (sck_rise) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == BC_W'(PKT_BYTES)) begin
                                overrun <= 1'b1;
                            end else begin
                                for (int i = 0; i < PKT_BYTES; i++)
                                    if (byte_cnt == BC_W'(i)) stage[i] <= shift_next;
                                byte_cnt <= byte_cnt + BC_W'(1);
                                // The checksum byte itself is excluded from the XOR.
                                if (byte_cnt != BC_W'(PKT_BYTES-1))
                                    csum <= csum ^ shift_next;
                            end
                        end
                    end
                end
                ST_CHECK:  state <= frame_good ? ST_COMMIT : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Error counters and register bank. The bank is written on the CHECK to
    // COMMIT transition so that it becomes visible together with pkt_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_data    <= '0;
            field_flags   <= '0;
            sensor_seen   <= '0;
            pkt_valid     <= 1'b0;
            pkt_sensor    <= '0;
            frame_err_cnt <= 8'd0;
            csum_err_cnt  <= 8'd0;
            id_err_cnt    <= 8'd0;
        end else begin
            pkt_valid <= 1'b0;
            if (state == ST_CHECK) begin
                if (len_bad || hdr_bad) begin
                    if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
                end else if (csum_bad) begin
                    if (csum_err_cnt != 8'hFF) csum_err_cnt <= csum_err_cnt + 8'd1;
                end else if (id_bad) begin
                    if (id_err_cnt != 8'hFF) id_err_cnt <= id_err_cnt + 8'd1;
                end else begin
                    for (int s = 0; s < NUM_SENSORS; s++) begin
                        if (commit_id == ID_W'(s)) begin
                            for (int f = 0; f < NUM_FIELDS; f++)
                                field_data[(s*NUM_FIELDS+f)*16 +: 16] <= {stage[2+2*f], stage[3+2*f]};
                            field_flags[s*8 +: 8] <= stage[PKT_BYTES-2];
                            sensor_seen[s]        <= 1'b1;
                        end
                    end
                    pkt_sensor <= commit_id;
                    pkt_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_sensor_packet_rx.sv
// tb_spi_sensor_packet_rx
// Directed bench for spi_sensor_packet_rx: drives SPI Mode 0 frames built from
// hand-written byte vectors and checks the bank, strobes and error counters
// against hand-computed values.
module tb_spi_sensor_packet_rx;

    localparam int NS = 2;
    localparam int NF = 6;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cs_n  = 1'b1;
    logic                 sck   = 1'b0;
    logic                 sdi   = 1'b0;
    logic [NS*NF*16-1:0]  field_data;
    logic [NS*8-1:0]      field_flags;
    logic [NS-1:0]        sensor_seen;
    logic                 pkt_valid;
    logic [0:0]           pkt_sensor;
    logic [7:0]           frame_err_cnt;
    logic [7:0]           csum_err_cnt;
    logic [7:0]           id_err_cnt;
    logic                 busy;

    int checks   = 0;
    int errors   = 0;
    int pv_count = 0;
    logic [7:0] tx_buf [0:31];

    spi_sensor_packet_rx #(
        .NUM_SENSORS (NS),
        .NUM_FIELDS  (NF),
        .HEADER_BYTE (8'hAA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cs_n          (cs_n),
        .sck           (sck),
        .sdi           (sdi),
        .field_data    (field_data),
        .field_flags   (field_flags),
        .sensor_seen   (sensor_seen),
        .pkt_valid     (pkt_valid),
        .pkt_sensor    (pkt_sensor),
        .frame_err_cnt (frame_err_cnt),
        .csum_err_cnt  (csum_err_cnt),
        .id_err_cnt    (id_err_cnt),
        .busy          (busy)
    );

    // 100 MHz system clock; SCK runs at 12.5 MHz, well inside the 4x ratio.
    always #5 clk = ~clk;

    // Count strobes mid-cycle so every pulse is seen exactly once.
    always @(negedge clk) begin
        if (pkt_valid === 1'b1) pv_count++;
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] fld(input int s, input int f);
        return field_data[(s*NF+f)*16 +: 16];
    endfunction

    task send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sdi = b[i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    // One full frame: tx_buf[0..n_bytes-1] plus n_bits leading bits of the
    // next byte. CS rises 1 ns after a clk rising edge.
    task applyStimulus(input int n_bytes, input int n_bits);
        cs_n = 1'b0;
        #50;
        for (int i = 0; i < n_bytes; i++) send_bits(tx_buf[i], 8);
        if (n_bits > 0) send_bits(tx_buf[n_bytes], n_bits);
        #20;
        @(posedge clk);
        #1 cs_n = 1'b1;
    endtask

    task settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task pulse_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Reference frame; checksum E0 is correct only for id 00.
    task load_frame_a(input logic [7:0] id);
        tx_buf[0]  = 8'hAA; tx_buf[1]  = id;
        tx_buf[2]  = 8'h01; tx_buf[3]  = 8'hF4;
        tx_buf[4]  = 8'hFF; tx_buf[5]  = 8'h38;
        tx_buf[6]  = 8'h00; tx_buf[7]  = 8'h64;
        tx_buf[8]  = 8'h07; tx_buf[9]  = 8'hD0;
        tx_buf[10] = 8'hF8; tx_buf[11] = 8'h30;
        tx_buf[12] = 8'h00; tx_buf[13] = 8'h00;
        tx_buf[14] = 8'h03; tx_buf[15] = 8'hE0;
    endtask

    task fix_csum();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 15; i++) x = x ^ tx_buf[i];
        tx_buf[15] = x;
    endtask

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_seen", 32'(sensor_seen), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err_cnt), 32'd0);
        checkOutput("rst_bank_zero", 32'(|field_data), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Valid frame for sensor 0
        load_frame_a(8'h00);
        applyStimulus(16, 0);
        settle();
        checkOutput("v1_pv_count", 32'(pv_count), 32'd1);
        checkOutput("v1_s0f0", 32'(fld(0,0)), 32'h01F4);
        checkOutput("v1_s0f1", 32'(fld(0,1)), 32'hFF38);
        checkOutput("v1_s0f2", 32'(fld(0,2)), 32'h0064);
        checkOutput("v1_s0f3", 32'(fld(0,3)), 32'h07D0);
        checkOutput("v1_s0f4", 32'(fld(0,4)), 32'hF830);
        checkOutput("v1_s0f5", 32'(fld(0,5)), 32'h0000);
        checkOutput("v1_flags0", 32'(field_flags[7:0]), 32'h03);
        checkOutput("v1_seen", 32'(sensor_seen), 32'h1);
        checkOutput("v1_sensor", 32'(pkt_sensor), 32'd0);
        checkOutput("v1_counters", {8'd0, frame_err_cnt, csum_err_cnt, id_err_cnt}, 32'd0);
        checkOutput("v1_busy", 32'(busy), 32'd0);

        // Sensor 1 with the same data, then sensor 0 with new data
        load_frame_a(8'h01);
        fix_csum();
        applyStimulus(16, 0);
        settle();
        checkOutput("v2_pv_count", 32'(pv_count), 32'd2);
        checkOutput("v2_seen", 32'(sensor_seen), 32'h3);
        checkOutput("v2_sensor", 32'(pkt_sensor), 32'd1);
        checkOutput("v2_s1f0", 32'(fld(1,0)), 32'h01F4);
        checkOutput("v2_s1f4", 32'(fld(1,4)), 32'hF830);
        checkOutput("v2_flags1", 32'(field_flags[15:8]), 32'h03);
        for (int i = 0; i < 6; i++) begin
            tx_buf[2+2*i] = 8'h00;
            tx_buf[3+2*i] = 8'(i + 1);
        end
        tx_buf[1]  = 8'h00;
        tx_buf[14] = 8'h80;
        fix_csum();
        applyStimulus(16, 0);
        settle();
        checkOutput("v3_pv_count", 32'(pv_count), 32'd3);
        checkOutput("v3_sensor", 32'(pkt_sensor), 32'd0);
        checkOutput("v3_s0f0", 32'(fld(0,0)), 32'h0001);
        checkOutput("v3_s0f5", 32'(fld(0,5)), 32'h0006);
        checkOutput("v3_flags0", 32'(field_flags[7:0]), 32'h80);
        checkOutput("v3_s1f1", 32'(fld(1,1)), 32'hFF38);
        checkOutput("v3_flags1", 32'(field_flags[15:8]), 32'h03);

        // Corrupted checksum
        load_frame_a(8'h00);
        tx_buf[15] = 8'hE1;
        applyStimulus(16, 0);
        settle();
        checkOutput("cs_pv_count", 32'(pv_count), 32'd3);
        checkOutput("cs_csum_err", 32'(csum_err_cnt), 32'd1);
        checkOutput("cs_s0f0_kept", 32'(fld(0,0)), 32'h0001);
        checkOutput("cs_flags0_kept", 32'(field_flags[7:0]), 32'h80);

        // Short, bit-misaligned and long frames
        load_frame_a(8'h00);
        applyStimulus(10, 0);
        settle();
        applyStimulus(15, 3);
        settle();
        tx_buf[16] = 8'h00;
        applyStimulus(17, 0);
        settle();
        checkOutput("fr_frame_err", 32'(frame_err_cnt), 32'd3);
        checkOutput("fr_pv_count", 32'(pv_count), 32'd3);
        applyStimulus(16, 0);
        settle();
        checkOutput("fr_recover_pv", 32'(pv_count), 32'd4);
        checkOutput("fr_recover_s0f0", 32'(fld(0,0)), 32'h01F4);
        checkOutput("fr_recover_flags0", 32'(field_flags[7:0]), 32'h03);
        // CS pulse with no SCK edges
        cs_n = 1'b0;
        #100;
        @(posedge clk);
        #1 cs_n = 1'b1;
        settle();
        checkOutput("fr_zero_sck", 32'(frame_err_cnt), 32'd4);

        // Bad header, bad id, then counter saturation
        pulse_reset();
        checkOutput("r2_frame_err", 32'(frame_err_cnt), 32'd0);
        checkOutput("r2_s0f0", 32'(fld(0,0)), 32'h0000);
        load_frame_a(8'h00);
        tx_buf[0] = 8'h55;
        fix_csum();
        applyStimulus(16, 0);
        settle();
        checkOutput("hdr_frame_err", 32'(frame_err_cnt), 32'd1);
        load_frame_a(8'h05);
        fix_csum();
        applyStimulus(16, 0);
        settle();
        checkOutput("id_id_err", 32'(id_err_cnt), 32'd1);
        checkOutput("id_frame_err", 32'(frame_err_cnt), 32'd1);
        checkOutput("id_csum_err", 32'(csum_err_cnt), 32'd0);
        checkOutput("id_pv_count", 32'(pv_count), 32'd4);
        checkOutput("id_seen", 32'(sensor_seen), 32'd0);
        tx_buf[0] = 8'h55;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1, 0);
            repeat (6) @(posedge clk);
        end
        settle();
        checkOutput("sat_frame_err", 32'(frame_err_cnt), 32'd255);
        checkOutput("sat_id_err", 32'(id_err_cnt), 32'd1);

        // Reset in the middle of a frame
        pulse_reset();
        load_frame_a(8'h00);
        cs_n = 1'b0;
        #50;
        for (int i = 0; i < 7; i++) send_bits(tx_buf[i], 8);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_pkt_valid", 32'(pkt_valid), 32'd0);
        checkOutput("mid_rst_counters", {8'd0, frame_err_cnt, csum_err_cnt, id_err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 7; i < 16; i++) send_bits(tx_buf[i], 8);
        #20;
        @(posedge clk);
        #1 cs_n = 1'b1;
        settle();
        checkOutput("mid_pv_count", 32'(pv_count), 32'd4);
        checkOutput("mid_frame_err", 32'(frame_err_cnt), 32'd0);
        checkOutput("mid_seen", 32'(sensor_seen), 32'd0);
        checkOutput("mid_bank_zero", 32'(|field_data), 32'd0);

        // Next full frame commits two cycles after the synchronised CS rise
        applyStimulus(16, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("lat_pv_early", 32'(pkt_valid), 32'd0);
        checkOutput("lat_bank_early", 32'(fld(0,0)), 32'h0000);
        @(posedge clk);
        #1;
        checkOutput("lat_pv_on", 32'(pkt_valid), 32'd1);
        checkOutput("lat_bank_on", 32'(fld(0,0)), 32'h01F4);
        checkOutput("lat_sensor", 32'(pkt_sensor), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_pv_off", 32'(pkt_valid), 32'd0);
        settle();
        checkOutput("lat_pv_count", 32'(pv_count), 32'd5);
        checkOutput("lat_seen", 32'(sensor_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sensor_packet_rx.md
Name: spi_sensor_packet_rx

Overview:
Next-generation read-only SPI Mode 0 slave for sensor packets from the Arduino master. SCK, CS and MOSI are oversampled into the single FPGA clock domain, so there is no SCK-clocked logic and no cross-domain snapshot. The block generalises the packet to a configurable field count and multiple sensor channels, and adds an XOR checksum, framing checks, error counters and a per-sensor register bank. It feeds the MCU-facing SPI slave.

Parameters:
NUM_SENSORS, 2, number of sensor channels; sensor-ID byte selects the bank entry.
NUM_FIELDS, 6, number of signed 16-bit fields per packet.
HEADER_BYTE, 8'hAA, required value of byte 0.
PKT_BYTES, 2*NUM_FIELDS+4, derived and not overridable: header, id, fields, flags, checksum.

Ports:
clk  in  1  FPGA system clock; must be at least 4x the SCK frequency.
rst_n  in  1  asynchronous active-low reset.
cs_n  in  1  SPI chip select from Arduino, active low, asynchronous.
sck  in  1  SPI clock, asynchronous.
sdi  in  1  MOSI, asynchronous.
field_data  out  NUM_SENSORS*NUM_FIELDS*16  per-sensor field bank; sensor s, field f at bits [(s*NUM_FIELDS+f)*16 +: 16], signed.
field_flags  out  NUM_SENSORS*8  last committed flags byte per sensor.
sensor_seen  out  NUM_SENSORS  bit s set once sensor s has committed a valid packet.
pkt_valid  out  1  one-cycle strobe on every committed packet.
pkt_sensor  out  $clog2(NUM_SENSORS) (min 1)  sensor ID of the last commit; valid while pkt_valid is high and held afterwards.
frame_err_cnt  out  8  saturating count of short, long and bad-header frames.
csum_err_cnt  out  8  saturating count of checksum failures.
id_err_cnt  out  8  saturating count of frames with sensor ID >= NUM_SENSORS.
busy  out  1  high while state is RECV.

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0; FSM to IDLE; synchronisers preset to cs_n=1, sck=0.
- Input sync: 2-FF synchroniser on each of cs_n, sck, sdi; a third flop on sck and cs_n gives edge detection.
- sdi is sampled on the detected SCK rising edge using the synchronised sdi value, MSB first.
- SCK edges while synchronised cs_n is high are ignored.
- FSM states:
  - IDLE: on CS falling edge, clear bit_cnt, byte_cnt, running XOR and overrun; go to RECV.
  - RECV: shift bits in. When the 8th bit lands, write the byte into the staging buffer at byte_cnt and increment byte_cnt. XOR the byte into the running checksum only for byte_cnt < PKT_BYTES-1.
  - RECV, overrun: a byte completing when byte_cnt == PKT_BYTES sets overrun and is not stored.
  - RECV to CHECK: on CS rising edge.
  - CHECK (1 cycle): evaluate the frame in this order:
    - byte_cnt != PKT_BYTES, or bit_cnt != 0, or overrun: frame_err++.
    - Else header != HEADER_BYTE: frame_err++.
    - Else computed XOR != last byte: csum_err++.
    - Else id >= NUM_SENSORS: id_err++.
    - Else go to COMMIT.
    - Any error returns to IDLE with no bank change.
  - COMMIT (1 cycle): write staged fields and flags into the bank slot for the ID; set sensor_seen[id]; load pkt_sensor; pkt_valid=1 for exactly this cycle; go to IDLE.
- Latency: pkt_valid and the bank update occur 2 clk cycles after the clk in which the synchronised CS rising edge is detected.
- Field byte order: field f = {byte[2+2f], byte[3+2f]}; flags = byte[PKT_BYTES-2].
- Counters saturate at 255; no wrap.
- A CS falling edge during CHECK or COMMIT is held pending and processed in IDLE on the next cycle. No bits are lost, because at least 4 clk cycles pass before the first SCK edge.
- A CS pulse with zero SCK edges counts as a short frame.
- Bank entries that are not addressed keep their values.
- rst_n asserted mid-packet aborts it immediately. After release the FSM waits for a fresh CS falling edge, so a partial frame still in progress is never taken as a packet start.

Test Plan:
- Valid 16-byte frame, AA 00 01 F4 FF 38 00 64 07 D0 F8 30 00 00 03 cs -> pkt_valid pulses once; sensor 0 fields = 500, -200, 100, 2000, -2000, 0; flags 0x03; sensor_seen=01; all counters 0.
- Same frame with ID=01, then a frame with ID=00 and different data -> both bank slots hold their own data; sensor_seen=11; pkt_sensor tracks the last commit.
- Checksum byte corrupted (XOR 0x01) -> no pkt_valid, bank unchanged, csum_err_cnt=1.
- CS released after 10 bytes, then after 15 bytes plus 3 bits, then a 17-byte frame -> frame_err_cnt=3, no commits; a following valid frame commits normally.
- Header 0x55, then ID=05 with a correct checksum -> frame_err_cnt=1, id_err_cnt=1; 300 bad-header frames -> frame_err_cnt saturates at 255.
- rst_n pulsed low at byte 7 of a frame -> all outputs 0, no pkt_valid for that frame; the next full valid frame commits with latency 2 clk after the synchronised CS rise.
